demux_1_to_4_buf: RTL and testbench
===================================

DEMUX_1_TO_4_BUF -- requirements
Module: demux_1_to_4_buf

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (input, 1, rising-edge clock) and rst (input, 1, synchronous active-high reset).
REQ-002 in_valid  input  1  source offers a word.
REQ-003 in_ready  output  1  block accepts the offered word this cycle.
REQ-004 in_data  input  13  data word.
REQ-005 in_sel  input  2  destination channel 0..3.
REQ-006 out_valid  output  4  bit k: channel k holds a word.
REQ-007 out_ready  input  4  bit k: sink k takes the word this cycle.
REQ-008 out_data0..out_data3  output  13 each  channel k data.
REQ-009 cnt_clr  input  1  synchronous clear of all transfer counters.
REQ-010 cnt0..cnt3  output  8 each  saturating count of completed output handshakes per channel.
REQ-011 busy  output  1  OR of out_valid.

Function
REQ-012 Each channel SHALL contain a one-entry holding register with two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
REQ-013 in_ready SHALL equal !out_valid[in_sel] || out_ready[in_sel]; in_ready has no combinational dependence on in_valid or in_data.
REQ-014 Accept: when in_valid && in_ready, the block SHALL load in_data into channel in_sel and set it FULL at the next edge (1-cycle latency, input handshake to out_valid).
REQ-015 Drain: when out_valid[k] && out_ready[k], channel k SHALL go EMPTY at the next edge unless it is loaded in the same cycle.
REQ-016 Simultaneous drain and load on the same channel SHALL leave it FULL with the new word (pass-through at full throughput, 1 word/cycle).
REQ-017 in_data and in_sel SHALL be sampled only on accept; channels not addressed SHALL be unaffected by the input handshake.
REQ-018 The four channels SHALL drain independently and in parallel.
REQ-019 While out_valid[k] && !out_ready[k], out_data_k SHALL remain stable.
REQ-020 While channel k is EMPTY, out_data_k SHALL hold its last value (0 after reset), never X.
REQ-021 When the addressed channel is FULL and not draining, in_ready SHALL be 0 and the offered word SHALL be held by the source (no drop, no overwrite).
REQ-022 cnt_k SHALL increment on each output handshake of channel k and saturate at 255.
REQ-023 cnt_clr SHALL zero all counters at the next edge; clear SHALL win over a simultaneous increment.

Reset
REQ-024 While rst=1, at the clock edge: all channels EMPTY, out_data0..3=0, cnt0..3=0, busy=0.
REQ-025 Handshakes in a cycle with rst=1 SHALL be ignored; buffered words SHALL be discarded on reset mid-operation.
REQ-026 After reset, in_ready SHALL be 1 for any in_sel.

Structure
REQ-027 Package demux_pkg SHALL hold DATA_W=13, NCH=4, SEL_W=2, CNT_W=8 and enum chan_state_t {EMPTY, FULL}.
REQ-028 Sub-module demux_chan (holding register, state, saturating counter) SHALL be instantiated four times; the top level holds only the select/ready decode.

Verification
REQ-029 Reset, then send 13'h0ABC to sel=2 with all out_ready=0 -> out_valid=4'b0100 one cycle later, out_data2=13'h0ABC, other out_data=0, busy=1.
REQ-030 Channel 1 FULL, out_ready=0, offer 13'h1FFF to sel=1 -> in_ready=0, out_data1 unchanged; raise out_ready[1] -> word accepted that cycle, next cycle out_data1=13'h1FFF, cnt1=1.
REQ-031 Streaming 8 words to sel=0 with out_ready[0]=1 constantly -> in_ready stays 1, one word per cycle, cnt0=8, order preserved.
REQ-032 Channel 3 FULL and stalled, offer word to sel=0 -> accepted immediately; channel 3 unaffected.
REQ-033 300 handshakes on channel 2 -> cnt2=255; assert cnt_clr together with a handshake -> cnt2=0.
REQ-034 Assert rst with channels 0 and 3 FULL and in_valid=1 -> next cycle out_valid=0, all counters 0, offered word not stored.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared widths and channel state encoding for the 1-to-4 buffered demux.
package demux_pkg;

    localparam int unsigned DATA_W = 13;
    localparam int unsigned NCH    = 4;
    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

endpackage

// File: rtl/demux_chan.sv
// One output channel: single-entry holding register, EMPTY/FULL state and a
// saturating count of completed output handshakes.
module demux_chan
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    input  logic              i_clr,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_cnt
);

    chan_state_t       r_state;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_drain;

    assign w_drain = (r_state == FULL) && i_ready;

    // A load in the same cycle as a drain keeps the channel FULL with the new word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else if (i_load) begin
            r_state <= FULL;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_state <= EMPTY;
        end
    end

    // Clear has priority over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_drain && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;

endmodule

// File: rtl/demux_1_to_4_buf.sv
// 1-to-4 demultiplexer with a one-word buffer per output channel; the top only
// decodes the select and the input ready, the channels hold all state.
module demux_1_to_4_buf
    import demux_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]  in_sel,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [DATA_W-1:0] out_data0,
    output logic [DATA_W-1:0] out_data1,
    output logic [DATA_W-1:0] out_data2,
    output logic [DATA_W-1:0] out_data3,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1,
    output logic [CNT_W-1:0]  cnt2,
    output logic [CNT_W-1:0]  cnt3,
    output logic              busy
);

    logic [NCH-1:0]    w_load;
    logic [DATA_W-1:0] w_data [NCH];
    logic [CNT_W-1:0]  w_cnt  [NCH];

    // Ready depends only on the addressed channel's state and its sink.
    assign in_ready = !out_valid[in_sel] || out_ready[in_sel];

    always_comb begin
        w_load = '0;
        if (in_valid && in_ready) begin
            w_load[in_sel] = 1'b1;
        end
    end

    for (genvar k = 0; k < NCH; k++) begin : g_chan
        demux_chan u_chan (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_data  (in_data),
            .i_ready (out_ready[k]),
            .i_clr   (cnt_clr),
            .o_valid (out_valid[k]),
            .o_data  (w_data[k]),
            .o_cnt   (w_cnt[k])
        );
    end

    assign out_data0 = w_data[0];
    assign out_data1 = w_data[1];
    assign out_data2 = w_data[2];
    assign out_data3 = w_data[3];
    assign cnt0      = w_cnt[0];
    assign cnt1      = w_cnt[1];
    assign cnt2      = w_cnt[2];
    assign cnt3      = w_cnt[3];
    assign busy      = |out_valid;

endmodule

// File: tb/tb_demux_1_to_4_buf.sv
// Self-checking bench for demux_1_to_4_buf: directed scenarios plus random
// traffic against a per-channel behavioural model.
module tb_demux_1_to_4_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [12:0] out_data0, out_data1, out_data2, out_data3;
    logic        cnt_clr;
    logic [7:0]  cnt0, cnt1, cnt2, cnt3;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model: one slot per channel plus an unbounded-then-clamped count.
    bit          m_full [4];
    logic [12:0] m_data [4];
    int          m_cnt  [4];

    logic [87:0] act;
    assign act = {out_valid, out_data3, out_data2, out_data1, out_data0, cnt3, cnt2, cnt1, cnt0};

    always #5 clk = ~clk;

    demux_1_to_4_buf dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .cnt_clr   (cnt_clr),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .cnt2      (cnt2),
        .cnt3      (cnt3),
        .busy      (busy)
    );

    function automatic logic [87:0] exp_vec();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        return {v, m_data[3], m_data[2], m_data[1], m_data[0],
                8'(m_cnt[3]), 8'(m_cnt[2]), 8'(m_cnt[1]), 8'(m_cnt[0])};
    endfunction

    function automatic logic exp_ready();
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    function automatic logic exp_busy();
        return m_full[0] | m_full[1] | m_full[2] | m_full[3];
    endfunction

    task automatic model_step();
        bit acc;
        bit drn;
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                m_full[k] = 0; m_data[k] = '0; m_cnt[k] = 0;
            end
        end else begin
            acc = in_valid && (!m_full[in_sel] || out_ready[in_sel]);
            for (int k = 0; k < 4; k++) begin
                drn = m_full[k] && out_ready[k];
                if (cnt_clr) m_cnt[k] = 0;
                else if (drn && m_cnt[k] < 255) m_cnt[k] = m_cnt[k] + 1;
                if (acc && in_sel == 2'(k)) begin
                    m_full[k] = 1; m_data[k] = in_data;
                end else if (drn) begin
                    m_full[k] = 0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [12:0] d,
                         input logic [3:0] ordy, input logic clr, input logic r);
        in_valid = v; in_sel = s; in_data = d; out_ready = ordy; cnt_clr = clr; rst = r;
        #1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 4'b0000, 0, 1);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act !== 88'h0) begin
            errors++; $display("FAIL reset_state: got %h want %h", act, 88'h0);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        for (int s = 0; s < 4; s++) begin
            drive(1, 2'(s), 13'h0, 4'b0000, 0, 0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL reset_ready sel=%0d: got %b want 1", s, in_ready);
            end
        end
        drive(0, 0, 0, 4'b0000, 0, 0);
    endtask

    task automatic test_single();
        do_reset();
        drive(1, 2'd2, 13'h0ABC, 4'b0000, 0, 0);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
        checks++;
        if (out_valid !== 4'b0100 || out_data2 !== 13'h0ABC || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_load: got valid=%b data2=%h busy=%b want 0100 0abc 1",
                     out_valid, out_data2, busy);
        end
        checks++;
        if (out_data0 !== 13'h0 || out_data1 !== 13'h0 || out_data3 !== 13'h0) begin
            errors++;
            $display("FAIL single_others: got %h %h %h want 0 0 0", out_data0, out_data1, out_data3);
        end
        checks++;
        if (act !== exp_vec()) begin
            errors++; $display("FAIL single_model: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1, 2'd1, 13'h0123, 4'b0000, 0, 0);
        tick();
        drive(1, 2'd1, 13'h1FFF, 4'b0000, 0, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_stall_ready: got %b want 0", in_ready);
        end
        tick();
        checks++;
        if (out_data1 !== 13'h0123 || out_valid !== 4'b0010) begin
            errors++; $display("FAIL bp_hold: got data1=%h valid=%b want 0123 0010", out_data1, out_valid);
        end
        drive(1, 2'd1, 13'h1FFF, 4'b0010, 0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready);
        end
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
        checks++;
        if (out_data1 !== 13'h1FFF || cnt1 !== 8'd1 || out_valid !== 4'b0010) begin
            errors++;
            $display("FAIL bp_passthru: got data1=%h cnt1=%0d valid=%b want 1fff 1 0010",
                     out_data1, cnt1, out_valid);
        end
    endtask

    task automatic test_stream();
        logic [12:0] words [8];
        do_reset();
        for (int i = 0; i < 8; i++) words[i] = 13'($urandom);
        for (int i = 0; i < 8; i++) begin
            drive(1, 2'd0, words[i], 4'b0001, 0, 0);
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_ready[%0d]: got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_data0 !== words[i] || out_valid[0] !== 1'b1) begin
                errors++;
                $display("FAIL stream_order[%0d]: got %h v=%b want %h v=1", i, out_data0, out_valid[0], words[i]);
            end
        end
        drive(0, 0, 0, 4'b0001, 0, 0);
        tick();
        checks++;
        if (cnt0 !== 8'd8 || out_valid !== 4'b0000) begin
            errors++; $display("FAIL stream_count: got cnt0=%0d valid=%b want 8 0000", cnt0, out_valid);
        end
    endtask

    task automatic test_cross();
        do_reset();
        drive(1, 2'd3, 13'h0777, 4'b0000, 0, 0);
        tick();
        drive(1, 2'd0, 13'h0555, 4'b0000, 0, 0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL cross_ready: got %b want 1", in_ready);
        end
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
        checks++;
        if (out_valid !== 4'b1001 || out_data3 !== 13'h0777 || out_data0 !== 13'h0555) begin
            errors++;
            $display("FAIL cross_state: got valid=%b d3=%h d0=%h want 1001 0777 0555",
                     out_valid, out_data3, out_data0);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1, 2'd2, 13'(i), 4'b0100, 0, 0);
            tick();
        end
        checks++;
        if (cnt2 !== 8'd255) begin
            errors++; $display("FAIL sat_count: got %0d want 255", cnt2);
        end
        drive(0, 0, 0, 4'b0100, 1, 0);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
        checks++;
        if (cnt2 !== 8'd0 || out_valid[2] !== 1'b0) begin
            errors++; $display("FAIL sat_clear: got cnt2=%0d v2=%b want 0 0", cnt2, out_valid[2]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 2'd0, 13'h0101, 4'b0000, 0, 0);
        tick();
        drive(1, 2'd3, 13'h0303, 4'b0000, 0, 0);
        tick();
        drive(1, 2'd1, 13'h0AAA, 4'b1111, 0, 1);
        tick();
        drive(0, 0, 0, 4'b0000, 0, 0);
        checks++;
        if (act !== 88'h0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid: got %h busy=%b want 0 0", act, busy);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 13'($urandom), 4'($urandom),
                  1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 150) == 0));
            checks++;
            if (in_ready !== exp_ready()) begin
                errors++; $display("FAIL rand_ready[%0d]: got %b want %b", i, in_ready, exp_ready());
            end
            tick();
            checks++;
            if (act !== exp_vec() || busy !== exp_busy()) begin
                errors++;
                $display("FAIL rand_state[%0d]: got %h busy=%b want %h busy=%b",
                         i, act, busy, exp_vec(), exp_busy());
            end
        end
        drive(0, 0, 0, 4'b0000, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0; m_data[k] = '0; m_cnt[k] = 0;
        end
        drive(0, 0, 0, 4'b0000, 0, 1);
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_stream();
        test_cross();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
